// File: rtl/alu_multicycle_exec_if.sv
// Request/response bundle for alu_multicycle_exec: op/operand request port,
// result port with valid/ready handshakes, and the pipeline flush.
interface alu_multicycle_exec_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_in_1;
  logic [DATA_WIDTH-1:0] alu_in_2;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;
  logic                  illegal_op;

  modport master (
    output in_valid, alu_op, alu_in_1, alu_in_2, flush, out_ready,
    input  in_ready, out_valid, alu_result, alu_zero, illegal_op
  );

  modport slave (
    input  in_valid, alu_op, alu_in_1, alu_in_2, flush, out_ready,
    output in_ready, out_valid, alu_result, alu_zero, illegal_op
  );
endinterface

// File: rtl/alu_multicycle_exec.sv
// Multi-cycle ALU: logic/arithmetic ops finish in one cycle, SLL/SRL iterate SHIFT_STEP bits
// per cycle. Define ALU_SRA_EN to add op 1100 (arithmetic right shift).
module alu_multicycle_exec #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  alu_multicycle_exec_if.slave bus
);
  localparam int unsigned SW      = $clog2(DATA_WIDTH);
  localparam logic [SW:0] LP_STEP = (SW+1)'(SHIFT_STEP);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b1000,
    OP_SLL = 4'b1010,
    OP_SRL = 4'b1011,
    OP_SRA = 4'b1100
  } op_t;

  state_t                r_state;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;
  logic                  r_illegal;
  logic [DATA_WIDTH-1:0] r_work;
  logic [SW-1:0]         r_rem;
  logic                  r_left;
  logic                  r_arith;

  logic                  w_in_ready;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_ill;
  logic                  w_shift;
  logic                  w_left;
  logic                  w_arith;
  logic [SW-1:0]         w_shamt;
  logic                  w_last;
  logic [SW-1:0]         w_step;
  logic [DATA_WIDTH-1:0] w_shifted;

  assign w_in_ready = !bus.flush &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && bus.out_ready));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_shamt    = bus.alu_in_2[SW-1:0];

  always_comb begin
    w_res   = '0;
    w_ill   = 1'b0;
    w_shift = 1'b0;
    w_left  = 1'b0;
    w_arith = 1'b0;
    case (bus.alu_op)
      OP_ADD: w_res = bus.alu_in_1 + bus.alu_in_2;
      OP_SUB: w_res = bus.alu_in_1 + ~bus.alu_in_2 + DATA_WIDTH'(1);
      OP_AND: w_res = bus.alu_in_1 & bus.alu_in_2;
      OP_OR:  w_res = bus.alu_in_1 | bus.alu_in_2;
      OP_XOR: w_res = bus.alu_in_1 ^ bus.alu_in_2;
      // Shifts preload the operand so a zero shift amount completes as a pass-through.
      OP_SLL: begin w_res = bus.alu_in_1; w_shift = 1'b1; w_left = 1'b1; end
      OP_SRL: begin w_res = bus.alu_in_1; w_shift = 1'b1; end
`ifdef ALU_SRA_EN
      OP_SRA: begin w_res = bus.alu_in_1; w_shift = 1'b1; w_arith = 1'b1; end
`endif
      default: w_ill = 1'b1;
    endcase
  end

  assign w_last = ({1'b0, r_rem} <= LP_STEP);
  assign w_step = w_last ? r_rem : LP_STEP[SW-1:0];

  always_comb begin
    if (r_left)
      w_shifted = r_work << w_step;
    else if (r_arith)
      w_shifted = $unsigned($signed(r_work) >>> w_step);
    else
      w_shifted = r_work >> w_step;
  end

  // Accept is handled ahead of the state case: it can only fire from IDLE or a draining DONE,
  // and both load the next operation identically.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_work      <= '0;
      r_rem       <= '0;
      r_left      <= 1'b0;
      r_arith     <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      if (w_shift && (w_shamt != '0)) begin
        r_state     <= S_SHIFT;
        r_out_valid <= 1'b0;
        r_work      <= bus.alu_in_1;
        r_rem       <= w_shamt;
        r_left      <= w_left;
        r_arith     <= w_arith;
      end else begin
        r_state     <= S_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_illegal   <= w_ill;
      end
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_shifted;
            r_zero      <= (w_shifted == '0);
            r_illegal   <= 1'b0;
          end else begin
            r_work <= w_shifted;
            r_rem  <= r_rem - LP_STEP[SW-1:0];
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.alu_result = r_result;
  assign bus.alu_zero   = r_zero;
  assign bus.illegal_op = r_illegal;
endmodule

// File: tb/tb_alu_multicycle_exec.sv
// Self-checking bench: two ALU instances (SHIFT_STEP 1 and 8) share one stimulus stream and are
// checked against an arithmetic reference model for results, flags and latency.
module tb_alu_multicycle_exec;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        t_in_valid;
  logic        t_flush;
  logic        t_out_ready;
  logic [3:0]  t_op;
  logic [31:0] t_a;
  logic [31:0] t_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  alu_multicycle_exec_if #(.DATA_WIDTH(32)) ifa ();
  alu_multicycle_exec_if #(.DATA_WIDTH(32)) ifb ();

  alu_multicycle_exec #(.DATA_WIDTH(32), .SHIFT_STEP(1)) u_dut_s1 (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  alu_multicycle_exec #(.DATA_WIDTH(32), .SHIFT_STEP(8)) u_dut_s8 (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  assign ifa.in_valid  = t_in_valid;
  assign ifa.alu_op    = t_op;
  assign ifa.alu_in_1  = t_a;
  assign ifa.alu_in_2  = t_b;
  assign ifa.flush     = t_flush;
  assign ifa.out_ready = t_out_ready;
  assign ifb.in_valid  = t_in_valid;
  assign ifb.alu_op    = t_op;
  assign ifb.alu_in_1  = t_a;
  assign ifb.alu_in_2  = t_b;
  assign ifb.flush     = t_flush;
  assign ifb.out_ready = t_out_ready;

  logic        o_rdy  [2];
  logic        o_vld  [2];
  logic        o_zero [2];
  logic        o_ill  [2];
  logic [31:0] o_res  [2];
  assign o_rdy[0] = ifa.in_ready;   assign o_rdy[1] = ifb.in_ready;
  assign o_vld[0] = ifa.out_valid;  assign o_vld[1] = ifb.out_valid;
  assign o_zero[0] = ifa.alu_zero;  assign o_zero[1] = ifb.alu_zero;
  assign o_ill[0] = ifa.illegal_op; assign o_ill[1] = ifb.illegal_op;
  assign o_res[0] = ifa.alu_result; assign o_res[1] = ifb.alu_result;

  function automatic int unsigned stp(input int d);
    return (d == 0) ? 1 : 8;
  endfunction

  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill,
                                output int unsigned sh, output bit is_shift);
    r = 32'h0; ill = 1'b0; sh = int'(b[4:0]); is_shift = 1'b0;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0100: r = a & b;
      4'b0101: r = a | b;
      4'b1000: r = a ^ b;
      4'b1010: begin r = a << sh; is_shift = 1'b1; end
      4'b1011: begin r = a >> sh; is_shift = 1'b1; end
`ifdef ALU_SRA_EN
      4'b1100: begin r = $unsigned($signed(a) >>> sh); is_shift = 1'b1; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int unsigned exp_latency(input int unsigned sh, input bit is_shift,
                                             input int unsigned step);
    return (is_shift && sh > 0) ? 1 + (sh + step - 1) / step : 1;
  endfunction

  task automatic idle_inputs();
    t_in_valid = 1'b0; t_flush = 1'b0; t_out_ready = 1'b1;
    t_op = 4'h0; t_a = 32'h0; t_b = 32'h0;
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        ei;
    int unsigned sh;
    bit          iss;
    bit          seen [2];
    int unsigned lat  [2];
    logic [31:0] cr   [2];
    logic        cz   [2];
    logic        ci   [2];
    model(op, a, b, er, ei, sh, iss);
    seen[0] = 1'b0; seen[1] = 1'b0;
    t_op = op; t_a = a; t_b = b; t_in_valid = 1'b1; t_out_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_rdy[d] !== 1'b1) begin
        n_err++;
        $display("FAIL op_in_ready dut%0d op=%b: got %b expected 1", d, op, o_rdy[d]);
      end
    end
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      for (int d = 0; d < 2; d++) begin
        if (!seen[d] && o_vld[d] === 1'b1) begin
          seen[d] = 1'b1; lat[d] = c; cr[d] = o_res[d]; cz[d] = o_zero[d]; ci[d] = o_ill[d];
        end
      end
      if (seen[0] && seen[1]) break;
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (!seen[d]) begin
        n_err++;
        $display("FAIL op_timeout dut%0d op=%b a=%h b=%h: out_valid never seen, expected within %0d",
                 d, op, a, b, exp_latency(sh, iss, stp(d)));
      end else begin
        if (cr[d] !== er) begin
          n_err++;
          $display("FAIL op_result dut%0d op=%b a=%h b=%h: got %h expected %h", d, op, a, b, cr[d], er);
        end
        n_vec++;
        if (cz[d] !== (er == 32'h0)) begin
          n_err++;
          $display("FAIL op_zero dut%0d op=%b: got %b expected %b", d, op, cz[d], (er == 32'h0));
        end
        n_vec++;
        if (ci[d] !== ei) begin
          n_err++;
          $display("FAIL op_illegal dut%0d op=%b: got %b expected %b", d, op, ci[d], ei);
        end
        n_vec++;
        if (lat[d] != exp_latency(sh, iss, stp(d))) begin
          n_err++;
          $display("FAIL op_latency dut%0d op=%b shamt=%0d: got %0d expected %0d",
                   d, op, sh, lat[d], exp_latency(sh, iss, stp(d)));
        end
      end
    end
    if (!(seen[0] && seen[1])) begin
      t_flush = 1'b1; @(posedge clk); #1; t_flush = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; idle_inputs();
    t_in_valid = 1'b1; t_op = 4'b0000; t_a = 32'h1; t_b = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_vld[d] !== 1'b0 || o_res[d] !== 32'h0 || o_ill[d] !== 1'b0 || o_zero[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got vld=%b res=%h ill=%b zero=%b expected 0/0/0/0",
                 d, o_vld[d], o_res[d], o_ill[d], o_zero[d]);
      end
    end
    reset_n = 1'b1; t_in_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_rdy[d] !== 1'b1) begin
        n_err++;
        $display("FAIL reset_in_ready dut%0d: got %b expected 1", d, o_rdy[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift();
    t_op = 4'b1010; t_a = 32'h1; t_b = 32'd31; t_in_valid = 1'b1; t_out_ready = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int c = 0; c < 35; c++) begin
      n_vec++;
      if (o_vld[0] !== 1'b0 || o_res[0] !== 32'h0) begin
        n_err++;
        $display("FAIL reset_mid_shift cycle%0d: got vld=%b res=%h expected 0/0", c, o_vld[0], o_res[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_single_cycle();
    do_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    do_op(4'b0001, 32'd5, 32'd5);
    do_op(4'b1000, 32'hF0F0_F0F0, 32'hFFFF_0000);
    do_op(4'b0100, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
    do_op(4'b0101, 32'h1234_0000, 32'h0000_5678);
  endtask

  task automatic test_shifts();
    do_op(4'b1010, 32'h1, 32'd31);
    do_op(4'b1011, 32'h8000_0000, 32'd4);
    do_op(4'b1010, 32'hA5A5_1234, 32'hFFFF_FFE0);
    do_op(4'b1011, 32'hFFFF_FFFF, 32'hABCD_EF08);
    do_op(4'b1010, 32'hFFFF_FFFF, 32'd9);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  bop [8];
    logic [31:0] ba  [8];
    logic [31:0] bb  [8];
    logic [3:0]  pool [6];
    logic [31:0] er;
    logic        ei;
    int unsigned sh;
    bit          iss;
    pool[0] = 4'b0000; pool[1] = 4'b0001; pool[2] = 4'b0100;
    pool[3] = 4'b0101; pool[4] = 4'b1000; pool[5] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      bop[i] = pool[$urandom_range(0, 5)]; ba[i] = $urandom; bb[i] = $urandom;
    end
    bop[0] = 4'b0001; ba[0] = 32'd9; bb[0] = 32'd9;
    t_out_ready = 1'b1;
    t_op = bop[0]; t_a = ba[0]; t_b = bb[0]; t_in_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i <= 8; i++) begin
      model(bop[i-1], ba[i-1], bb[i-1], er, ei, sh, iss);
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (o_vld[d] !== 1'b1 || o_res[d] !== er || o_ill[d] !== ei || o_zero[d] !== (er == 32'h0)
            || o_rdy[d] !== 1'b1) begin
          n_err++;
          $display("FAIL b2b dut%0d idx%0d: got vld=%b res=%h ill=%b zero=%b rdy=%b expected 1/%h/%b/%b/1",
                   d, i - 1, o_vld[d], o_res[d], o_ill[d], o_zero[d], o_rdy[d], er, ei, (er == 32'h0));
        end
      end
      if (i < 8) begin
        t_op = bop[i]; t_a = ba[i]; t_b = bb[i];
      end else begin
        t_in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    t_op = 4'b0000; t_a = 32'd3; t_b = 32'd4; t_in_valid = 1'b1; t_out_ready = 1'b0;
    @(posedge clk); #1;
    t_a = 32'd10; t_b = 32'd20;
    for (int k = 0; k < 10; k++) begin
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (o_vld[d] !== 1'b1 || o_res[d] !== 32'd7 || o_rdy[d] !== 1'b0 || o_zero[d] !== 1'b0) begin
          n_err++;
          $display("FAIL backpressure_hold dut%0d cycle%0d: got vld=%b res=%h rdy=%b zero=%b expected 1/7/0/0",
                   d, k, o_vld[d], o_res[d], o_rdy[d], o_zero[d]);
        end
      end
      @(posedge clk); #1;
    end
    t_out_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_rdy[d] !== 1'b1) begin
        n_err++;
        $display("FAIL backpressure_release_ready dut%0d: got %b expected 1", d, o_rdy[d]);
      end
    end
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_vld[d] !== 1'b1 || o_res[d] !== 32'd30) begin
        n_err++;
        $display("FAIL backpressure_next dut%0d: got vld=%b res=%h expected 1/0000001e",
                 d, o_vld[d], o_res[d]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    t_op = 4'b1011; t_a = $urandom | 32'h8000_0000;
    t_b = ($urandom & 32'hFFFF_FFE0) | 32'd20;
    t_in_valid = 1'b1; t_out_ready = 1'b1;
    @(posedge clk); #1;
    t_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    t_flush = 1'b1; t_in_valid = 1'b1; t_op = 4'b0000; t_a = 32'd1; t_b = 32'd1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_rdy[d] !== 1'b0) begin
        n_err++;
        $display("FAIL flush_in_ready dut%0d: got %b expected 0", d, o_rdy[d]);
      end
    end
    @(posedge clk); #1;
    t_flush = 1'b0; t_in_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (o_rdy[d] !== 1'b1) begin
        n_err++;
        $display("FAIL flush_idle dut%0d: got in_ready %b expected 1", d, o_rdy[d]);
      end
    end
    for (int c = 0; c < 25; c++) begin
      for (int d = 0; d < 2; d++) begin
        n_vec++;
        if (o_vld[d] !== 1'b0) begin
          n_err++;
          $display("FAIL flush_no_result dut%0d cycle%0d: got out_valid %b expected 0", d, c, o_vld[d]);
        end
      end
      @(posedge clk); #1;
    end
    do_op(4'b0000, 32'd100, 32'd23);
  endtask

  task automatic test_illegal_and_sra();
    do_op(4'b1100, 32'h8000_0000, 32'd4);
    do_op(4'b1100, 32'h4000_0000, 32'd30);
    do_op(4'b0010, $urandom, $urandom);
    do_op(4'b1111, $urandom, $urandom);
  endtask

  task automatic test_random();
    logic [3:0] pool [11];
    logic [3:0] op;
    int unsigned k;
    pool[0] = 4'b0000; pool[1] = 4'b0001; pool[2] = 4'b0100; pool[3] = 4'b0101;
    pool[4] = 4'b1000; pool[5] = 4'b1010; pool[6] = 4'b1011; pool[7] = 4'b1100;
    pool[8] = 4'b0010; pool[9] = 4'b1111; pool[10] = 4'b1010;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 11);
      if (k == 11) op = 4'($urandom_range(0, 15));
      else         op = pool[k];
      do_op(op, $urandom, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_shifts();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal_and_sra();
    test_reset_mid_shift();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
